// File: rtl/panel_mem_sequencer.sv
// panel_mem_sequencer: runs PDP-8/e front-panel console commands (clear,
// extended-address load, address load, deposit, examine). It owns the console
// PC and the IF/DF fields, and borrows the shared memory port from the CPU
// for deposit and examine cycles.
module panel_mem_sequencer #(
    parameter int ACK_TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cleard,
    input  logic        extd_addrd,
    input  logic        addr_loadd,
    input  logic        depd,
    input  logic        examd,
    input  logic [11:0] sr,
    input  logic        cpu_halted,
    input  logic        cpu_req,
    input  logic        mem_ack,
    input  logic [11:0] mem_rdata,
    output logic        mem_sel,
    output logic        mem_req,
    output logic        mem_we,
    output logic [14:0] mem_addr,
    output logic [11:0] mem_wdata,
    output logic [11:0] pc,
    output logic [2:0]  ifld,
    output logic [2:0]  dfld,
    output logic [11:0] mb,
    output logic        busy,
    output logic        overrun,
    output logic        err
);

    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ARB, ACCESS, DONE} state_t;
    typedef enum logic [2:0] {CMD_NONE, CMD_CLR, CMD_EXT, CMD_ADDR, CMD_DEP, CMD_EXAM} cmd_t;

    // A command and the switch register value it was issued with.
    typedef struct packed {
        cmd_t        cmd;
        logic [11:0] sr;
    } cmd_req_t;

    state_t          state;
    cmd_req_t        pend;
    logic            pend_vld;
    logic [TW-1:0]   tcnt;

    cmd_req_t        new_req;
    logic            new_vld;
    cmd_req_t        disp;
    logic            slot_free;
    logic            take;
    logic            drop;

    // Priority-decode the incoming pulses; lower-priority bits are discarded.
    always_comb begin
        new_req.sr  = sr;
        new_req.cmd = CMD_NONE;
        if (cleard)          new_req.cmd = CMD_CLR;
        else if (extd_addrd) new_req.cmd = CMD_EXT;
        else if (addr_loadd) new_req.cmd = CMD_ADDR;
        else if (depd)       new_req.cmd = CMD_DEP;
        else if (examd)      new_req.cmd = CMD_EXAM;
        new_vld = (new_req.cmd != CMD_NONE);
    end

    // Pending-slot policy for pulses that arrive while busy. In DONE the slot
    // is being drained this cycle, so it counts as free. A clear may replace a
    // queued non-clear command; anything else hitting a full slot is dropped.
    always_comb begin
        slot_free = !pend_vld || (state == DONE);
        take      = new_vld && (slot_free ||
                                (new_req.cmd == CMD_CLR && pend.cmd != CMD_CLR));
        drop      = new_vld && !take;
        disp      = (state == DONE && pend_vld) ? pend : new_req;
    end

    // Sequencer FSM: command dispatch, port arbitration, access and timeout.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            pend      <= '0;
            pend_vld  <= 1'b0;
            tcnt      <= '0;
            mem_sel   <= 1'b0;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wdata <= '0;
            pc        <= '0;
            ifld      <= '0;
            dfld      <= '0;
            mb        <= '0;
            overrun   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    mem_sel <= 1'b0;
                    if (state == DONE) begin
                        pend_vld <= 1'b0;
                        // Queued command is dispatched now; a fresh pulse refills the slot.
                        if (pend_vld && new_vld) begin
                            pend     <= new_req;
                            pend_vld <= 1'b1;
                        end
                    end
                    case (disp.cmd)
                        CMD_CLR: begin
                            pend_vld <= 1'b0;
                            overrun  <= 1'b0;
                            err      <= 1'b0;
                            mb       <= '0;
                            state    <= IDLE;
                        end
                        CMD_EXT: begin
                            ifld  <= disp.sr[5:3];
                            dfld  <= disp.sr[2:0];
                            state <= IDLE;
                        end
                        CMD_ADDR: begin
                            pc    <= disp.sr;
                            state <= IDLE;
                        end
                        CMD_DEP, CMD_EXAM: begin
                            mem_we    <= (disp.cmd == CMD_DEP);
                            mem_wdata <= disp.sr;
                            state     <= ARB;
                        end
                        default: state <= IDLE;
                    endcase
                end

                ARB: begin
                    if (new_req.cmd == CMD_CLR) begin
                        // Clear before the port is taken aborts the pending access.
                        pend_vld <= 1'b0;
                        overrun  <= 1'b0;
                        err      <= 1'b0;
                        mb       <= '0;
                        state    <= IDLE;
                    end else begin
                        if (take) begin
                            pend     <= new_req;
                            pend_vld <= 1'b1;
                        end
                        if (drop) overrun <= 1'b1;
                        // mem_sel and mem_req rise together so mem_sel never moves under a request.
                        if (cpu_halted && !cpu_req) begin
                            mem_sel <= 1'b1;
                            mem_req <= 1'b1;
                            tcnt    <= '0;
                            state   <= ACCESS;
                        end
                    end
                end

                ACCESS: begin
                    if (take) begin
                        pend     <= new_req;
                        pend_vld <= 1'b1;
                    end
                    if (drop) overrun <= 1'b1;
                    // Ack wins over a timeout landing on the same edge.
                    if (mem_ack) begin
                        mb      <= mem_we ? mem_wdata : mem_rdata;
                        pc      <= pc + 12'd1;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else if (tcnt == TO_LAST) begin
                        err     <= 1'b1;
                        mem_req <= 1'b0;
                        state   <= DONE;
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign mem_addr = {ifld, pc};
    assign busy     = (state != IDLE) || pend_vld;

endmodule
